// File: rtl/cntr3_cmd_ctrl.sv
// cntr3_cmd_ctrl: command sequencer in front of the load/increment counter.
// It accepts READ/LOAD/INC/CLEAR commands over valid/ready and drives the
// counter's ld/inc/data pins. It stops incrementing at all-ones so the
// counter never wraps, and returns one response per command.
module cntr3_cmd_ctrl #(
   parameter int WIDTH = 3,
   parameter int EVT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [1:0]       cmd_op,
   input  logic [WIDTH-1:0] cmd_arg,
   output logic             cnt_ld,
   output logic             cnt_inc,
   output logic [WIDTH-1:0] cnt_data,
   input  logic [WIDTH-1:0] cnt_q,
   output logic             rsp_valid,
   output logic [WIDTH-1:0] rsp_count,
   output logic             rsp_sat,
   output logic             sat_sticky,
   output logic [EVT_W-1:0] sat_events
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LD   = 2'd1,
      ST_INC  = 2'd2,
      ST_RSP  = 2'd3
   } state_t;

   localparam logic [1:0]       OP_READ  = 2'b00;
   localparam logic [1:0]       OP_LOAD  = 2'b01;
   localparam logic [1:0]       OP_INC   = 2'b10;
   localparam logic [1:0]       OP_CLEAR = 2'b11;
   localparam logic [WIDTH-1:0] CNT_MAX  = {WIDTH{1'b1}};
   localparam logic [WIDTH-1:0] CNT_ZERO = {WIDTH{1'b0}};
   localparam logic [WIDTH-1:0] REM_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
   localparam logic [EVT_W-1:0] EVT_MAX  = {EVT_W{1'b1}};
   localparam logic [EVT_W-1:0] EVT_ZERO = {EVT_W{1'b0}};
   localparam logic [EVT_W-1:0] EVT_ONE  = {{(EVT_W-1){1'b0}}, 1'b1};

   state_t           state_r;
   state_t           state_s;
   logic [1:0]       op_r;
   logic [WIDTH-1:0] rem_r;
   logic             sat_r;
   logic [WIDTH-1:0] cnt_data_r;
   logic             sat_sticky_r;
   logic [EVT_W-1:0] sat_events_r;
   logic             accept_s;
   logic             at_max_s;

   assign accept_s = cmd_valid && (state_r == ST_IDLE) && !rst;
   assign at_max_s = (cnt_q == CNT_MAX);

   // Next-state decode and counter/response strobes; everything forced low in reset
   always_comb begin
      state_s    = state_r;
      cmd_ready  = 1'b0;
      cnt_ld     = 1'b0;
      cnt_inc    = 1'b0;
      cnt_data   = CNT_ZERO;
      rsp_valid  = 1'b0;
      rsp_count  = CNT_ZERO;
      rsp_sat    = 1'b0;
      sat_sticky = 1'b0;
      sat_events = EVT_ZERO;
      if (rst) begin
         state_s = ST_IDLE;
      end else begin
         cnt_data   = cnt_data_r;
         sat_sticky = sat_sticky_r;
         sat_events = sat_events_r;
         case (state_r)
            ST_IDLE: begin
               cmd_ready = 1'b1;
               if (cmd_valid) begin
                  case (cmd_op)
                     OP_READ:  state_s = ST_RSP;
                     OP_LOAD:  state_s = ST_LD;
                     OP_CLEAR: state_s = ST_LD;
                     OP_INC: begin
                        if (cmd_arg == CNT_ZERO) begin
                           state_s = ST_RSP;
                        end else begin
                           state_s = ST_INC;
                        end
                     end
                     default:  state_s = ST_IDLE;
                  endcase
               end else begin
                  state_s = ST_IDLE;
               end
            end
            ST_LD: begin
               cnt_ld  = 1'b1;
               state_s = ST_RSP;
            end
            ST_INC: begin
               // cnt_q is registered in the counter, so this path has no loop
               if (at_max_s) begin
                  state_s = ST_RSP;
               end else begin
                  cnt_inc = 1'b1;
                  if (rem_r == REM_ONE) begin
                     state_s = ST_RSP;
                  end else begin
                     state_s = ST_INC;
                  end
               end
            end
            ST_RSP: begin
               rsp_valid = 1'b1;
               rsp_count = cnt_q;
               rsp_sat   = sat_r;
               state_s   = ST_IDLE;
            end
            default: state_s = ST_IDLE;
         endcase
      end
   end

   // FSM state register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Capture the accepted command: opcode, load data and remaining step count
   always_ff @(posedge clk) begin
      if (rst) begin
         op_r       <= OP_READ;
         rem_r      <= CNT_ZERO;
         cnt_data_r <= CNT_ZERO;
      end else if (accept_s) begin
         op_r  <= cmd_op;
         rem_r <= (cmd_op == OP_INC) ? cmd_arg : CNT_ZERO;
         if (cmd_op == OP_LOAD) begin
            cnt_data_r <= cmd_arg;
         end else if (cmd_op == OP_CLEAR) begin
            cnt_data_r <= CNT_ZERO;
         end
      end else if ((state_r == ST_INC) && !at_max_s) begin
         rem_r <= rem_r - REM_ONE;
      end
   end

   // Per-command saturation latch: set when INC finds the counter at all-ones
   always_ff @(posedge clk) begin
      if (rst) begin
         sat_r <= 1'b0;
      end else if ((state_r == ST_INC) && at_max_s) begin
         sat_r <= 1'b1;
      end else if (state_r == ST_RSP) begin
         sat_r <= 1'b0;
      end
   end

   // Sticky saturation flag and saturating event counter
   always_ff @(posedge clk) begin
      if (rst) begin
         sat_sticky_r <= 1'b0;
         sat_events_r <= EVT_ZERO;
      end else if ((state_r == ST_LD) && (op_r == OP_CLEAR)) begin
         sat_sticky_r <= 1'b0;
      end else if ((state_r == ST_RSP) && sat_r) begin
         sat_sticky_r <= 1'b1;
         if (sat_events_r != EVT_MAX) begin
            sat_events_r <= sat_events_r + EVT_ONE;
         end
      end
   end

endmodule

// File: tb/tb_cntr3_cmd_ctrl.sv
// Testbench for cntr3_cmd_ctrl with a behavioural 3-bit load/increment counter.
module tb_cntr3_cmd_ctrl;

   localparam int WIDTH = 3;
   localparam int EVT_W = 8;

   logic             clk = 1'b0;
   logic             rst;
   logic             cmd_valid;
   logic             cmd_ready;
   logic [1:0]       cmd_op;
   logic [WIDTH-1:0] cmd_arg;
   logic             cnt_ld;
   logic             cnt_inc;
   logic [WIDTH-1:0] cnt_data;
   logic [WIDTH-1:0] cnt_q = 3'd0;
   logic             rsp_valid;
   logic [WIDTH-1:0] rsp_count;
   logic             rsp_sat;
   logic             sat_sticky;
   logic [EVT_W-1:0] sat_events;

   int n_cmp  = 0;
   int n_fail = 0;

   cntr3_cmd_ctrl #(.WIDTH(WIDTH), .EVT_W(EVT_W)) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_arg(cmd_arg),
      .cnt_ld(cnt_ld), .cnt_inc(cnt_inc), .cnt_data(cnt_data), .cnt_q(cnt_q),
      .rsp_valid(rsp_valid), .rsp_count(rsp_count), .rsp_sat(rsp_sat),
      .sat_sticky(sat_sticky), .sat_events(sat_events)
   );

   always #5 clk = ~clk;

   // Downstream counter: registered output, rst over ld over inc, wraps naturally
   always @(posedge clk) begin
      if (rst)          cnt_q <= 3'd0;
      else if (cnt_ld)  cnt_q <= cnt_data;
      else if (cnt_inc) cnt_q <= cnt_q + 3'd1;
   end

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic check_inv();
      chk("ld_inc_exclusive", int'(cnt_ld && cnt_inc), 0);
      chk("inc_at_all_ones", int'(cnt_inc && (cnt_q == 3'd7)), 0);
      if (rsp_valid) chk("pulse_in_rsp", int'(cnt_ld || cnt_inc), 0);
   endtask

   // Issue one command and collect its pulses and response (bounded wait)
   task automatic run_cmd(input logic [1:0] op, input logic [2:0] arg,
                          output int cnt, output int sat, output int lat,
                          output int nld, output int ninc, output int ld_data);
      @(negedge clk);
      chk("ready_before_cmd", int'(cmd_ready), 1);
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_arg   = arg;
      @(posedge clk);
      #1 cmd_valid = 1'b0;
      cnt = -1; sat = -1; lat = -1; nld = 0; ninc = 0; ld_data = -1;
      for (int k = 1; (k <= 20) && (lat < 0); k++) begin
         @(negedge clk);
         check_inv();
         if (cnt_ld) begin
            nld++;
            ld_data = int'(cnt_data);
         end
         if (cnt_inc) ninc++;
         if (rsp_valid) begin
            lat = k;
            cnt = int'(rsp_count);
            sat = int'(rsp_sat);
         end
      end
   endtask

   typedef struct {
      logic [1:0] op;
      logic [2:0] arg;
      int e_count;
      int e_sat;
      int e_lat;
      int e_nld;
      int e_ninc;
      int e_ld_data;
      int e_sticky;
      int e_events;
   } vec_t;

   vec_t vecs[12];

   initial begin
      int cnt, sat, lat, nld, ninc, ld_data;
      int pulses;

      //          op     arg   cnt sat lat ld inc data stk ev
      vecs[0]  = '{2'b00, 3'd0, 0, 0, 1, 0, 0, -1, 0, 0};  // READ after reset
      vecs[1]  = '{2'b01, 3'd3, 3, 0, 2, 1, 0,  3, 0, 0};  // LOAD 3
      vecs[2]  = '{2'b10, 3'd2, 5, 0, 3, 0, 2, -1, 0, 0};  // INC 2 -> 5
      vecs[3]  = '{2'b01, 3'd5, 5, 0, 2, 1, 0,  5, 0, 0};  // LOAD 5
      vecs[4]  = '{2'b10, 3'd4, 7, 1, 4, 0, 2, -1, 1, 1};  // INC 4 saturates after 2
      vecs[5]  = '{2'b10, 3'd0, 7, 0, 1, 0, 0, -1, 1, 1};  // INC 0: no pulse
      vecs[6]  = '{2'b00, 3'd0, 7, 0, 1, 0, 0, -1, 1, 1};  // READ unchanged
      vecs[7]  = '{2'b10, 3'd3, 7, 1, 2, 0, 0, -1, 1, 2};  // INC from all-ones
      vecs[8]  = '{2'b11, 3'd5, 0, 0, 2, 1, 0,  0, 0, 2};  // CLEAR clears sticky only
      vecs[9]  = '{2'b10, 3'd7, 7, 0, 8, 0, 7, -1, 0, 2};  // INC max from 0, exact
      vecs[10] = '{2'b01, 3'd7, 7, 0, 2, 1, 0,  7, 0, 2};  // LOAD all-ones
      vecs[11] = '{2'b10, 3'd1, 7, 1, 2, 0, 0, -1, 1, 3};  // INC saturates at once

      rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_arg = 3'd0;

      // Reset: every output low for both reset cycles
      repeat (2) begin
         @(negedge clk);
         chk("rst_cmd_ready", int'(cmd_ready), 0);
         chk("rst_cnt_ld", int'(cnt_ld), 0);
         chk("rst_cnt_inc", int'(cnt_inc), 0);
         chk("rst_cnt_data", int'(cnt_data), 0);
         chk("rst_rsp_valid", int'(rsp_valid), 0);
         chk("rst_rsp_count", int'(rsp_count), 0);
         chk("rst_rsp_sat", int'(rsp_sat), 0);
         chk("rst_sat_sticky", int'(sat_sticky), 0);
         chk("rst_sat_events", int'(sat_events), 0);
      end
      rst = 1'b0;
      @(negedge clk);
      chk("ready_after_rst", int'(cmd_ready), 1);

      // Table-driven command sequence
      for (int i = 0; i < 12; i++) begin
         run_cmd(vecs[i].op, vecs[i].arg, cnt, sat, lat, nld, ninc, ld_data);
         chk($sformatf("v%0d_rsp_count", i), cnt, vecs[i].e_count);
         chk($sformatf("v%0d_rsp_sat", i), sat, vecs[i].e_sat);
         chk($sformatf("v%0d_latency", i), lat, vecs[i].e_lat);
         chk($sformatf("v%0d_ld_pulses", i), nld, vecs[i].e_nld);
         chk($sformatf("v%0d_inc_pulses", i), ninc, vecs[i].e_ninc);
         if (vecs[i].e_nld > 0) chk($sformatf("v%0d_ld_data", i), ld_data, vecs[i].e_ld_data);
         @(negedge clk);
         chk($sformatf("v%0d_rsp_one_cycle", i), int'(rsp_valid), 0);
         chk($sformatf("v%0d_sat_sticky", i), int'(sat_sticky), vecs[i].e_sticky);
         chk($sformatf("v%0d_sat_events", i), int'(sat_events), vecs[i].e_events);
      end

      // Reset in the middle of INC 7: CLEAR first, then abandon after 3 pulses
      run_cmd(2'b11, 3'd0, cnt, sat, lat, nld, ninc, ld_data);
      chk("pre_rst_clear_count", cnt, 0);
      @(negedge clk);
      cmd_valid = 1'b1; cmd_op = 2'b10; cmd_arg = 3'd7;
      @(posedge clk);
      #1 cmd_valid = 1'b0;
      pulses = 0;
      repeat (3) begin
         @(negedge clk);
         check_inv();
         chk("mid_inc_no_rsp", int'(rsp_valid), 0);
         if (cnt_inc) pulses++;
      end
      chk("mid_inc_pulses", pulses, 3);
      rst = 1'b1;
      #1;
      chk("inc_low_in_rst", int'(cnt_inc), 0);
      repeat (2) begin
         @(negedge clk);
         chk("rst_mid_inc_low", int'(cnt_inc), 0);
         chk("rst_mid_rsp_low", int'(rsp_valid), 0);
         chk("rst_mid_ready_low", int'(cmd_ready), 0);
      end
      rst = 1'b0;
      @(negedge clk);
      chk("ready_after_mid_rst", int'(cmd_ready), 1);
      chk("no_rsp_after_mid_rst", int'(rsp_valid), 0);
      run_cmd(2'b00, 3'd0, cnt, sat, lat, nld, ninc, ld_data);
      chk("read_after_mid_rst_count", cnt, 0);
      chk("read_after_mid_rst_lat", lat, 1);
      chk("read_after_mid_rst_sat", sat, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
